// File: rtl/bf_prog_mem.sv
// bf_prog_mem -- loadable Brainfuck program memory.
//
// Takes an ASCII program stream, discards every byte that is not one of the
// eight Brainfuck commands, packs the rest into 3-bit opcodes and stores them
// contiguously. While loading it keeps a stack of open '[' addresses so that
// every bracket pair gets a jump table entry pointing at its partner. The CPU
// core then reads opcode + jump target through a registered (1-cycle) port.
//
// Ports
//   clk, rst      single clock, synchronous active-high reset
//   load_start    pulse, restarts loading from any state
//   ld_valid/ld_data/ld_ready   ASCII byte stream, handshake on valid&&ready
//   load_end      pulse, end of program stream
//   prog_valid    program loaded and brackets balanced
//   load_err      00 none, 01 length overflow, 10 unbalanced, 11 nesting overflow
//   prog_len      number of stored commands (ADDR_W+1 bits, DEPTH representable)
//   addr          read address (PC)
//   code          opcode at addr (111 when out of range / no program)
//   jump_addr     partner bracket address at addr, 0 for non-brackets
//   rom_overrun   registered: !prog_valid || addr >= prog_len
module bf_prog_mem #(
   parameter int ADDR_W     = 10,
   parameter int DEPTH      = 1 << ADDR_W,
   parameter int NEST_DEPTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   output logic              ld_ready,
   input  logic              load_end,
   output logic              prog_valid,
   output logic [1:0]        load_err,
   output logic [ADDR_W:0]   prog_len,
   input  logic [ADDR_W-1:0] addr,
   output logic [2:0]        code,
   output logic [ADDR_W-1:0] jump_addr,
   output logic              rom_overrun
);

   localparam int SP_W   = $clog2(NEST_DEPTH + 1);
   localparam int STK_IW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [SP_W-1:0] NEST_L  = SP_W'(NEST_DEPTH);

   localparam logic [2:0] OP_OPEN  = 3'b011;
   localparam logic [2:0] OP_CLOSE = 3'b010;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIXUP, S_READY, S_ERROR} state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W:0]     prog_len_reg, prog_len_next;
   logic [SP_W-1:0]     sp_reg, sp_next;
   logic [1:0]          err_reg, err_next;
   logic                end_pend_reg, end_pend_next;
   logic [ADDR_W-1:0]   fix_addr_reg, fix_addr_next;   // '[' address to patch
   logic [ADDR_W-1:0]   fix_tgt_reg, fix_tgt_next;     // matching ']' address

   logic [2:0]          code_mem [0:DEPTH-1];
   logic [ADDR_W-1:0]   jmp_mem  [0:DEPTH-1];
   logic [ADDR_W-1:0]   stack_mem[0:NEST_DEPTH-1];

   logic [2:0]          code_rd_reg;
   logic [ADDR_W-1:0]   jmp_rd_reg;
   logic                overrun_reg;

   logic                is_cmd;
   logic [2:0]          op;
   logic                code_we, push_en, jmp_we;
   logic [ADDR_W-1:0]   jmp_waddr, jmp_wdata;
   logic [STK_IW-1:0]   top_idx;
   logic [ADDR_W-1:0]   stack_top;

   // Command decode; anything else is silently swallowed.
   always_comb begin
      is_cmd = 1'b1;
      op     = 3'b111;
      case (ld_data)
         8'h2B:   op = 3'b111;   // +
         8'h2D:   op = 3'b110;   // -
         8'h3E:   op = 3'b101;   // >
         8'h3C:   op = 3'b100;   // <
         8'h5B:   op = OP_OPEN;  // [
         8'h5D:   op = OP_CLOSE; // ]
         8'h2E:   op = 3'b001;   // .
         8'h2C:   op = 3'b000;   // ,
         default: is_cmd = 1'b0;
      endcase
   end

   assign top_idx   = STK_IW'(sp_reg - SP_W'(1));
   assign stack_top = stack_mem[top_idx];

   always_comb begin
      state_next    = state_reg;
      prog_len_next = prog_len_reg;
      sp_next       = sp_reg;
      err_next      = err_reg;
      end_pend_next = end_pend_reg;
      fix_addr_next = fix_addr_reg;
      fix_tgt_next  = fix_tgt_reg;
      code_we       = 1'b0;
      push_en       = 1'b0;
      jmp_we        = 1'b0;
      jmp_waddr     = prog_len_reg[ADDR_W-1:0];
      jmp_wdata     = stack_top;

      if (load_start) begin
         state_next    = S_LOAD;
         prog_len_next = '0;
         sp_next       = '0;
         err_next      = 2'b00;
         end_pend_next = 1'b0;
      end else begin
         case (state_reg)
            S_LOAD: begin
               if (ld_valid && is_cmd) begin
                  // The byte wins over a simultaneous load_end; the end is
                  // remembered and applied on a later quiet LOAD cycle.
                  if (load_end)
                     end_pend_next = 1'b1;
                  if (prog_len_reg == DEPTH_L) begin
                     state_next = S_ERROR;
                     err_next   = 2'b01;
                  end else if (op == OP_OPEN && sp_reg == NEST_L) begin
                     state_next = S_ERROR;
                     err_next   = 2'b11;
                  end else if (op == OP_CLOSE && sp_reg == '0) begin
                     state_next = S_ERROR;
                     err_next   = 2'b10;
                  end else begin
                     code_we       = 1'b1;
                     prog_len_next = prog_len_reg + (ADDR_W + 1)'(1);
                     if (op == OP_OPEN) begin
                        push_en = 1'b1;
                        sp_next = sp_reg + SP_W'(1);
                     end else if (op == OP_CLOSE) begin
                        // ']' entry written now; the '[' entry is patched
                        // in FIXUP since the jump table has one write port.
                        sp_next       = sp_reg - SP_W'(1);
                        jmp_we        = 1'b1;
                        fix_addr_next = stack_top;
                        fix_tgt_next  = prog_len_reg[ADDR_W-1:0];
                        state_next    = S_FIXUP;
                     end
                  end
               end else if (load_end || end_pend_reg) begin
                  end_pend_next = 1'b0;
                  if (sp_reg != '0) begin
                     state_next = S_ERROR;
                     err_next   = 2'b10;
                  end else begin
                     state_next = S_READY;
                  end
               end
            end
            S_FIXUP: begin
               jmp_we     = 1'b1;
               jmp_waddr  = fix_addr_reg;
               jmp_wdata  = fix_tgt_reg;
               state_next = S_LOAD;
               if (load_end)
                  end_pend_next = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         prog_len_reg <= '0;
         sp_reg       <= '0;
         err_reg      <= 2'b00;
         end_pend_reg <= 1'b0;
         fix_addr_reg <= '0;
         fix_tgt_reg  <= '0;
         overrun_reg  <= 1'b1;
      end else begin
         state_reg    <= state_next;
         prog_len_reg <= prog_len_next;
         sp_reg       <= sp_next;
         err_reg      <= err_next;
         end_pend_reg <= end_pend_next;
         fix_addr_reg <= fix_addr_next;
         fix_tgt_reg  <= fix_tgt_next;
         overrun_reg  <= (state_reg != S_READY) || ({1'b0, addr} >= prog_len_reg);
      end
   end

   // Program and jump memories: plain write port plus registered read,
   // no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (code_we)
         code_mem[prog_len_reg[ADDR_W-1:0]] <= op;
      if (jmp_we)
         jmp_mem[jmp_waddr] <= jmp_wdata;
      code_rd_reg <= code_mem[addr];
      jmp_rd_reg  <= jmp_mem[addr];
   end

   always_ff @(posedge clk) begin
      if (push_en)
         stack_mem[STK_IW'(sp_reg)] <= prog_len_reg[ADDR_W-1:0];
   end

   assign ld_ready    = (state_reg == S_LOAD);
   assign prog_valid  = (state_reg == S_READY);
   assign load_err    = err_reg;
   assign prog_len    = prog_len_reg;
   assign rom_overrun = overrun_reg;
   // Raw RAM data is masked here so the RAM output register stays reset-free.
   assign code        = overrun_reg ? 3'b111 : code_rd_reg;
   assign jump_addr   = (!overrun_reg && code_rd_reg[2:1] == 2'b01) ? jmp_rd_reg : '0;

endmodule

// File: tb/tb_bf_prog_mem.sv
// Bench for bf_prog_mem: a default-size instance (a) and a tiny one (b,
// ADDR_W=3, NEST_DEPTH=2) share one input stream. Read expectations are
// queued when the address is driven and popped when the data comes out.
module tb_bf_prog_mem;

   logic        clk = 1'b0;
   logic        rst, load_start, ld_valid, load_end;
   logic [7:0]  ld_data;
   logic [9:0]  addr;

   logic        rdy_a, pv_a, ovr_a;
   logic [1:0]  err_a;
   logic [10:0] len_a;
   logic [2:0]  code_a;
   logic [9:0]  jmp_a;

   logic        rdy_b, pv_b, ovr_b;
   logic [1:0]  err_b;
   logic [3:0]  len_b;
   logic [2:0]  code_b;
   logic [2:0]  jmp_b;

   int n_checks = 0;
   int n_fail   = 0;
   int st;

   typedef struct packed {
      logic       inst;
      logic [2:0] code;
      logic [9:0] jmp;
      logic       ovr;
   } rd_exp_t;
   rd_exp_t sb_q[$];

   always #5 clk = ~clk;

   bf_prog_mem u_dut_a (
      .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_ready(rdy_a), .load_end(load_end),
      .prog_valid(pv_a), .load_err(err_a), .prog_len(len_a), .addr(addr),
      .code(code_a), .jump_addr(jmp_a), .rom_overrun(ovr_a)
   );

   bf_prog_mem #(.ADDR_W(3), .NEST_DEPTH(2)) u_dut_b (
      .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_ready(rdy_b), .load_end(load_end),
      .prog_valid(pv_b), .load_err(err_b), .prog_len(len_b), .addr(addr[2:0]),
      .code(code_b), .jump_addr(jmp_b), .rom_overrun(ovr_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic do_end();
      load_end = 1'b1;
      tick();
      load_end = 1'b0;
   endtask

   // Streams a string; counts cycles spent waiting for ld_ready.
   task automatic send_str(input string s, output int stalls);
      int n;
      stalls = 0;
      for (int i = 0; i < s.len(); i++) begin
         n = 0;
         ld_valid = 1'b1;
         ld_data  = s[i];
         while (!(rdy_a || rdy_b) && n < 8) begin
            tick();
            n++;
         end
         if (n >= 8)
            chk("ready_timeout", 32'(n), 32'd0);
         stalls += n;
         tick();
      end
      ld_valid = 1'b0;
      $display("load \"%s\" stalls=%0d len_a=%0d err_a=%0b err_b=%0b", s, stalls, len_a, err_a, err_b);
   endtask

   task automatic rd(input logic [9:0] a, input logic [2:0] ec, input logic [9:0] ej,
                     input logic eo, input bit use_b, input logic [2:0] ecb,
                     input logic [2:0] ejb, input logic eob);
      rd_exp_t e;
      addr = a;
      sb_q.push_back('{inst: 1'b0, code: ec, jmp: ej, ovr: eo});
      if (use_b)
         sb_q.push_back('{inst: 1'b1, code: ecb, jmp: {7'd0, ejb}, ovr: eob});
      tick();
      $display("read addr=%0d a: code=%03b jump=%0d ovr=%0b  b: code=%03b jump=%0d ovr=%0b",
               a, code_a, jmp_a, ovr_a, code_b, jmp_b, ovr_b);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (e.inst == 1'b0) begin
            chk($sformatf("a_rd%0d_code", a), 32'(code_a), 32'(e.code));
            chk($sformatf("a_rd%0d_jump", a), 32'(jmp_a), 32'(e.jmp));
            chk($sformatf("a_rd%0d_ovr", a), 32'(ovr_a), 32'(e.ovr));
         end else begin
            chk($sformatf("b_rd%0d_code", a), 32'(code_b), 32'(e.code));
            chk($sformatf("b_rd%0d_jump", a), 32'(jmp_b), 32'(e.jmp));
            chk($sformatf("b_rd%0d_ovr", a), 32'(ovr_b), 32'(e.ovr));
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; load_end = 1'b0;
      ld_data = 8'h00; addr = '0;
      tick();
      tick();
      // Reset values
      chk("rst_ld_ready", 32'(rdy_a), 0);
      chk("rst_prog_valid", 32'(pv_a), 0);
      chk("rst_load_err", 32'(err_a), 0);
      chk("rst_prog_len", 32'(len_a), 0);
      chk("rst_code", 32'(code_a), 32'h7);
      chk("rst_jump", 32'(jmp_a), 0);
      chk("rst_overrun", 32'(ovr_a), 1);
      rst = 1'b0;
      tick();
      // load_end in IDLE does nothing
      do_end();
      chk("idle_end_prog_valid", 32'(pv_a), 0);
      chk("idle_end_ld_ready", 32'(rdy_a), 0);

      // 1: basic loop program, exactly DEPTH commands for instance b
      do_start();
      chk("t1_ld_ready", 32'(rdy_a), 1);
      send_str("+[->+<].", st);
      chk("t1_stalls", 32'(st), 1);
      do_end();
      chk("t1_prog_valid", 32'(pv_a), 1);
      chk("t1_prog_len", 32'(len_a), 8);
      chk("t1_load_err", 32'(err_a), 0);
      chk("t1_ready_low", 32'(rdy_a), 0);
      chk("t1_b_prog_len", 32'(len_b), 8);
      chk("t1_b_prog_valid", 32'(pv_b), 1);
      rd(10'd1, 3'b011, 10'd6, 1'b0, 1'b1, 3'b011, 3'd6, 1'b0);
      rd(10'd6, 3'b010, 10'd1, 1'b0, 1'b1, 3'b010, 3'd1, 1'b0);
      rd(10'd8, 3'b111, 10'd0, 1'b1, 1'b1, 3'b111, 3'd0, 1'b0);
      rd(10'd7, 3'b001, 10'd0, 1'b0, 1'b1, 3'b001, 3'd0, 1'b0);
      rd(10'd2, 3'b110, 10'd0, 1'b0, 1'b0, 3'b000, 3'd0, 1'b0);

      // 2: non-command bytes are dropped without stalling
      do_start();
      send_str("a+ b\n-x", st);
      chk("t2_stalls", 32'(st), 0);
      chk("t2_prog_len", 32'(len_a), 2);
      do_end();
      chk("t2_prog_valid", 32'(pv_a), 1);
      rd(10'd0, 3'b111, 10'd0, 1'b0, 1'b0, 3'b000, 3'd0, 1'b0);
      rd(10'd1, 3'b110, 10'd0, 1'b0, 1'b0, 3'b000, 3'd0, 1'b0);
      rd(10'd2, 3'b111, 10'd0, 1'b1, 1'b0, 3'b000, 3'd0, 1'b0);

      // 3: stray ']' then recovery
      do_start();
      send_str("]", st);
      chk("t3_load_err", 32'(err_a), 32'h2);
      chk("t3_prog_valid", 32'(pv_a), 0);
      chk("t3_ld_ready", 32'(rdy_a), 0);
      do_start();
      chk("t3_err_cleared", 32'(err_a), 0);
      send_str("+", st);
      do_end();
      chk("t3_prog_valid2", 32'(pv_a), 1);
      chk("t3_prog_len2", 32'(len_a), 1);

      // 4a: unbalanced at end
      do_start();
      send_str("[[]", st);
      tick();
      do_end();
      chk("t4_unbal_err", 32'(err_a), 32'h2);
      chk("t4_unbal_valid", 32'(pv_a), 0);

      // 4b: length overflow on instance b
      do_start();
      send_str("++++++++", st);
      chk("t4_b_err_before", 32'(err_b), 0);
      chk("t4_b_len_full", 32'(len_b), 8);
      send_str("+", st);
      chk("t4_b_err_len", 32'(err_b), 32'h1);
      chk("t4_b_len_after", 32'(len_b), 8);
      chk("t4_a_len", 32'(len_a), 9);

      // 5a: nesting overflow on instance b
      do_start();
      send_str("[[", st);
      chk("t5_b_err_before", 32'(err_b), 0);
      send_str("[", st);
      chk("t5_b_err_nest", 32'(err_b), 32'h3);
      chk("t5_a_err", 32'(err_a), 0);

      // 5b: load_end together with the closing ']'
      do_start();
      send_str("[+", st);
      ld_valid = 1'b1;
      ld_data  = 8'h5D;
      load_end = 1'b1;
      tick();
      ld_valid = 1'b0;
      load_end = 1'b0;
      chk("t5_fixup_ready", 32'(rdy_a), 0);
      chk("t5_fixup_valid", 32'(pv_a), 0);
      tick();
      chk("t5_load_valid", 32'(pv_a), 0);
      tick();
      chk("t5_prog_valid", 32'(pv_a), 1);
      chk("t5_b_prog_valid", 32'(pv_b), 1);
      chk("t5_prog_len", 32'(len_a), 3);
      rd(10'd0, 3'b011, 10'd2, 1'b0, 1'b1, 3'b011, 3'd2, 1'b0);
      rd(10'd2, 3'b010, 10'd0, 1'b0, 1'b1, 3'b010, 3'd0, 1'b0);
      rd(10'd1, 3'b111, 10'd0, 1'b0, 1'b1, 3'b111, 3'd0, 1'b0);

      // 6: reset in the middle of a load
      do_start();
      send_str("[+", st);
      rst = 1'b1;
      tick();
      chk("t6_ld_ready", 32'(rdy_a), 0);
      chk("t6_prog_valid", 32'(pv_a), 0);
      chk("t6_load_err", 32'(err_a), 0);
      chk("t6_prog_len", 32'(len_a), 0);
      chk("t6_code", 32'(code_a), 32'h7);
      chk("t6_jump", 32'(jmp_a), 0);
      chk("t6_overrun", 32'(ovr_a), 1);
      rst = 1'b0;
      rd(10'd0, 3'b111, 10'd0, 1'b1, 1'b0, 3'b000, 3'd0, 1'b0);
      do_start();
      send_str("-", st);
      rd(10'd0, 3'b111, 10'd0, 1'b1, 1'b0, 3'b000, 3'd0, 1'b0);
      do_end();
      rd(10'd0, 3'b110, 10'd0, 1'b0, 1'b0, 3'b000, 3'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
